// File: rtl/bitstream_byte_packer.sv
// bitstream_byte_packer
// Collects up to three carry-resolved bytes per cycle from the entropy encoder
// into a small FIFO and streams them out one byte per cycle on valid/ready,
// tagging the final byte of the stream. Bytes that cannot be stored are dropped
// and reported through a sticky overflow flag.
module bitstream_byte_packer #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                       top_clk,
  input  logic                       top_reset,
  input  logic [DATA_WIDTH-1:0]      in_bit_1,
  input  logic [DATA_WIDTH-1:0]      in_bit_2,
  input  logic [DATA_WIDTH-1:0]      in_last_bit,
  input  logic [1:0]                 in_flag,
  input  logic                       in_flag_last,
  output logic [DATA_WIDTH-1:0]      out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       out_done,
  output logic                       out_overflow,
  output logic [FIFO_ADDR_WIDTH:0]   out_level
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_L = (FIFO_ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_q, wr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [FIFO_ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       done_q, done_d;

  // Each entry is {last, byte}
  logic [DATA_WIDTH:0]        mem_q [DEPTH];

  logic [1:0]                 n_flag;
  logic [2:0]                 n_total;
  logic [FIFO_ADDR_WIDTH:0]   space;
  logic                       fits;
  logic                       accept;
  logic                       pop;
  logic                       head_last;
  logic [1:0]                 n_wr;
  logic [DATA_WIDTH:0]        wdata [3];
  logic [FIFO_ADDR_WIDTH-1:0] waddr [3];
  logic [2:0]                 wen;

  // Write-slot packing, space check, pointer/count/state next-state logic
  always_comb begin
    n_flag = 2'd0;
    wdata[0] = '0;
    wdata[1] = '0;
    wdata[2] = '0;
    // The last byte always lands in the slot right after the flagged bytes
    case (in_flag)
      2'b01: begin
        n_flag   = 2'd1;
        wdata[0] = {1'b0, in_bit_1};
        wdata[1] = {1'b1, in_last_bit};
      end
      2'b10: begin
        n_flag   = 2'd2;
        wdata[0] = {1'b0, in_bit_1};
        wdata[1] = {1'b0, in_bit_2};
        wdata[2] = {1'b1, in_last_bit};
      end
      default: begin
        n_flag   = 2'd0;
        wdata[0] = {1'b1, in_last_bit};
      end
    endcase

    n_total   = {1'b0, n_flag} + {2'b00, in_flag_last};
    space     = DEPTH_L - cnt_q;
    fits      = ({2'b00, space} >= {{FIFO_ADDR_WIDTH{1'b0}}, n_total});
    accept    = (state_q == S_RUN) && fits && (n_total != 3'd0);
    n_wr      = accept ? n_total[1:0] : 2'd0;
    pop       = (cnt_q != '0) && out_ready;
    head_last = mem_q[rd_q][DATA_WIDTH];

    wen[0] = (n_wr >= 2'd1);
    wen[1] = (n_wr >= 2'd2);
    wen[2] = (n_wr == 2'd3);
    for (int unsigned k = 0; k < 3; k++) begin
      waddr[k] = wr_q + FIFO_ADDR_WIDTH'(k);
    end

    if (state_q == S_RUN) begin
      ovf_d = ovf_q | (in_flag == 2'b11) | ~fits;
    end else begin
      ovf_d = ovf_q | (in_flag != 2'b00) | in_flag_last;
    end

    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_RUN:   if (accept && in_flag_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_RUN;
    endcase

    wr_d  = wr_q + FIFO_ADDR_WIDTH'(n_wr);
    rd_d  = rd_q + FIFO_ADDR_WIDTH'(pop);
    cnt_d = cnt_q + (FIFO_ADDR_WIDTH+1)'(n_wr) - (FIFO_ADDR_WIDTH+1)'(pop);
  end

  // Control state: pointers, occupancy, stream state and status flags
  always_ff @(posedge top_clk or negedge top_reset) begin
    if (!top_reset) begin
      state_q <= S_RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // FIFO storage; contents survive reset, occupancy decides visibility
  always_ff @(posedge top_clk) begin
    for (int unsigned k = 0; k < 3; k++) begin
      if (wen[k]) mem_q[waddr[k]] <= wdata[k];
    end
  end

  // Fall-through head presentation
  always_comb begin
    out_valid    = (cnt_q != '0);
    out_byte     = out_valid ? mem_q[rd_q][DATA_WIDTH-1:0] : '0;
    out_last     = out_valid & head_last;
    out_done     = done_q;
    out_overflow = ovf_q;
    out_level    = cnt_q;
  end

endmodule

// File: doc/bitstream_byte_packer.md
# bitstream_byte_packer

Output stage placed directly downstream of the entropy encoder top level. It consumes the encoder's carry-resolved byte outputs: up to two bytes per cycle, plus one final byte at end of stream. It queues them in order in a small FIFO and presents them one byte per cycle on a valid/ready interface, marking the last byte of the stream. The encoder cannot stall, so the block flags any byte it has to drop as overflow.

## Interface
- DATA_WIDTH, 8, byte width of all bitstream ports
- FIFO_ADDR_WIDTH, 4, log2 of FIFO depth (default depth 16 entries)
- top_clk  in  1  clock, all state on rising edge
- top_reset  in  1  asynchronous, active-low reset
- in_bit_1  in  DATA_WIDTH  first byte of the cycle (encoder OUT_BIT_1)
- in_bit_2  in  DATA_WIDTH  second byte of the cycle (encoder OUT_BIT_2)
- in_last_bit  in  DATA_WIDTH  final byte of the stream (encoder OUT_LAST_BIT)
- in_flag  in  2  00 none, 01 in_bit_1 only, 10 in_bit_1 then in_bit_2, 11 reserved
- in_flag_last  in  1  end of stream; in_last_bit is valid this cycle
- out_byte  out  DATA_WIDTH  head-of-FIFO byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_byte this cycle
- out_last  out  1  out_byte is the final byte of the stream
- out_done  out  1  one-cycle pulse after the final byte is accepted
- out_overflow  out  1  sticky; at least one write was dropped or the reserved flag was seen
- out_level  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy

## Operation
- **Storage:** FIFO of 2^FIFO_ADDR_WIDTH entries; each entry is {last, byte}.
  - Write pointer, read pointer and count registers; pointers wrap modulo depth.
- **Write count per cycle (n):**
  - in_flag=01 gives 1 byte; in_flag=10 gives 2 bytes; in_flag=00 gives 0.
  - in_flag_last=1 adds 1 more byte (in_last_bit), written after the flagged bytes with last=1.
  - n ranges from 0 to 3.
  - Write order: in_bit_1, in_bit_2, in_last_bit at consecutive pointer positions.
- **Space check:** all-or-nothing against the count at the start of the cycle. A simultaneous pop gives no credit.
  - If depth − count < n, no byte of that cycle is written and out_overflow sets.
- **Reserved flag:** in_flag=11 writes no flagged bytes and sets out_overflow. An in_flag_last in the same cycle is still processed.
- **Pop:** out_valid & out_ready advances the read pointer.
- **Count update:** count + written − popped.
- **States:**
  - RUN: accepts writes as above.
  - RUN → DRAIN on any accepted cycle with in_flag_last=1.
  - DRAIN: all writes are ignored; any nonzero in_flag or in_flag_last sets out_overflow.
  - DRAIN → DONE when the entry with last=1 is popped.
  - DONE: lasts one cycle; out_done=1 and writes are ignored as in DRAIN. Then DONE → RUN.
  - If in_flag_last=1 is dropped for lack of space, the state stays RUN.
- **out_overflow:** clears only on reset.

## Timing
- **Reset (top_reset=0, asynchronous):**
  - pointers, count and out_level=0; state RUN.
  - out_valid=0, out_last=0, out_done=0, out_overflow=0, out_byte=0.
  - FIFO memory is not cleared, but out_byte is forced to 0 while empty.
- **Latency:** a byte written at edge N appears on out_byte/out_valid immediately after edge N.
  - Output is fall-through: combinational read of the registered memory at the read pointer.
- **Head only:** out_byte, out_last and out_valid reflect only the head entry.
  - A pop at edge N presents the next entry after edge N.
- **Throughput:** one pop per cycle maximum; up to three writes per cycle.
- **Full with pop:** pop and write in the same cycle while full are permitted only if the write fits the pre-pop space; otherwise the write is dropped and the pop proceeds.
- **Empty:** out_ready with out_valid=0 has no effect.
- **Reset mid-stream:** discards all queued bytes instantly; no out_done is produced.
- **Deasserting reset:** synchronous release is the integrator's responsibility; the first edge after release may accept writes.

## Test plan
- **Single byte:** in_flag=01, in_bit_1=0xA5, out_ready=0 → after the edge: out_valid=1, out_byte=0xA5, out_level=1. Then out_ready=1 for one cycle → out_valid=0, out_level=0.
- **Ordering under back-pressure:** out_ready=0; cycle 1 in_flag=10 (0x12,0x34); cycle 2 in_flag=01 (0x56) → out_level=3. Then out_ready=1 → 0x12, 0x34, 0x56 on consecutive cycles, out_last=0 throughout.
- **End of stream:** in_flag=10 (0x01,0x02) with in_flag_last=1, in_last_bit=0x03, out_ready=1 → outputs 0x01, 0x02, 0x03 with out_last=1 only on 0x03. out_done=1 exactly one cycle after 0x03 is accepted. An in_flag=01 input during DRAIN sets out_overflow and queues nothing.
- **Overflow:** depth 16, out_ready=0; eight in_flag=10 cycles → out_level=16. Then in_flag=01 → nothing written, out_level=16, out_overflow=1. Overflow stays set after draining.
- **Wrap-around:** 40 cycles alternating in_flag=10 and 00 with out_ready=1 → all 40 bytes out in order across pointer wrap, no overflow, out_level never exceeds 2.
- **Async reset:** top_reset driven low between edges with out_level=5 → out_valid, out_level and out_overflow read 0 before the next edge.
